// File: rtl/fas_pkg.sv
// Shared defaults, rounding-mode constants and the width helper for the
// streaming FIR filter and its round/saturate stage.
package fas_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 20;
    localparam int DEF_TAPS   = 32;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 16;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    // Bits needed to index 'value' entries; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational post-scaling: optional half-up bias, arithmetic right shift,
// then clamp to the signed output range with a saturation indication.
module fir_round_sat
    import fas_pkg::*;
#(
    parameter int IN_W  = 41,
    parameter int SHIFT = DEF_SHIFT,
    parameter int ROUND = RND_HALF_UP,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

    // One guard bit keeps the bias addition from wrapping at the top of the range.
    localparam int EXT_W = IN_W + 1;
    localparam int BSH   = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] BIAS  =
        (ROUND == RND_HALF_UP && SHIFT > 0) ? (EXT_W'(1'b1) << BSH) : '0;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

    logic signed [EXT_W-1:0] biased_s;
    logic signed [EXT_W-1:0] shifted_s;

    // Bias, shift and clamp.
    always_comb begin
        biased_s  = {acc[IN_W-1], acc} + BIAS;
        shifted_s = biased_s >>> SHIFT;
        y         = shifted_s[OUT_W-1:0];
        sat       = 1'b0;
        if (shifted_s > MAX_V) begin
            y   = MAX_V[OUT_W-1:0];
            sat = 1'b1;
        end else if (shifted_s < MIN_V) begin
            y   = MIN_V[OUT_W-1:0];
            sat = 1'b1;
        end else begin
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/fir_stream_param.sv
// Streaming direct-form FIR: sample delay line, writable coefficient bank,
// registered products, then a registered rounded/saturated sum.
module fir_stream_param
    import fas_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int ROUND  = RND_HALF_UP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_valid,
    input  logic [DATA_W-1:0]        data,
    input  logic                     coef_we,
    input  logic [clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    input  logic                     clear,
    output logic [OUT_W-1:0]         fir_d,
    output logic                     fir_valid,
    output logic                     sat_flag
);

    localparam int AW     = clog2(TAPS);
    localparam int CNT_W  = clog2(TAPS + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    logic signed [DATA_W-1:0] x_r     [TAPS];
    logic signed [COEF_W-1:0] coef_r  [TAPS];
    logic signed [PROD_W-1:0] prod_r  [TAPS];
    logic [CNT_W-1:0]         cnt_r;
    logic                     s0_vld_r;
    logic                     s1_vld_r;

    logic                     pend_we_r;
    logic [AW-1:0]            pend_addr_r;
    logic signed [COEF_W-1:0] pend_wdata_r;

    logic                     addr_ok_s;
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [OUT_W-1:0]  rs_y_s;
    logic                     rs_sat_s;

    assign addr_ok_s = (32'(coef_addr) < 32'(TAPS));

    // Delay line, saturating sample count and the "complete sample" marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) x_r[k] <= '0;
            cnt_r    <= '0;
            s0_vld_r <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) x_r[k] <= '0;
            cnt_r    <= '0;
            s0_vld_r <= 1'b0;
        end else begin
            s0_vld_r <= data_valid && (cnt_r >= CNT_W'(TAPS - 1));
            if (data_valid) begin
                x_r[0] <= data;
                for (int k = 1; k < TAPS; k++) x_r[k] <= x_r[k-1];
                if (cnt_r < CNT_W'(TAPS)) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Writes land one cycle late so a sample accepted alongside a write
    // still multiplies against the previous coefficient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) coef_r[k] <= '0;
            pend_we_r    <= 1'b0;
            pend_addr_r  <= '0;
            pend_wdata_r <= '0;
        end else begin
            pend_we_r    <= coef_we && addr_ok_s;
            pend_addr_r  <= coef_addr;
            pend_wdata_r <= coef_wdata;
            if (pend_we_r) begin
                coef_r[pend_addr_r] <= pend_wdata_r;
            end
        end
    end

    // Stage 1: per-tap products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) prod_r[k] <= '0;
            s1_vld_r <= 1'b0;
        end else if (clear) begin
            s1_vld_r <= 1'b0;
        end else begin
            s1_vld_r <= s0_vld_r;
            for (int k = 0; k < TAPS; k++) begin
                prod_r[k] <= PROD_W'(x_r[k]) * PROD_W'(coef_r[k]);
            end
        end
    end

    // Full-precision sum of the registered products.
    always_comb begin
        acc_s = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_s = acc_s + ACC_W'(prod_r[k]);
        end
    end

    fir_round_sat #(
        .IN_W  (ACC_W),
        .SHIFT (SHIFT),
        .ROUND (ROUND),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .acc (acc_s),
        .y   (rs_y_s),
        .sat (rs_sat_s)
    );

    // Stage 2: result register; fir_d holds between valid results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fir_d     <= '0;
            fir_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            fir_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            fir_valid <= s1_vld_r;
            if (s1_vld_r) begin
                fir_d    <= rs_y_s;
                sat_flag <= sat_flag | rs_sat_s;
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_param.sv
// Directed bench for fir_stream_param (TAPS=4, rounding and truncating
// instances side by side) with a queue-based scoreboard and output monitor.
module tb_fir_stream_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_valid = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        coef_we = 1'b0;
    logic [1:0]  coef_addr = 2'd0;
    logic [19:0] coef_wdata = 20'h00000;
    logic        clear = 1'b0;

    logic [15:0] fir_d_r, fir_d_t;
    logic        fv_r, fv_t, sat_r, sat_t;

    typedef struct {
        logic [15:0] d_rnd;
        logic [15:0] d_trn;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    fir_stream_param #(.DATA_W(16), .COEF_W(20), .TAPS(4), .OUT_W(16), .SHIFT(16), .ROUND(1)) dut_rnd (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .clear(clear),
        .fir_d(fir_d_r), .fir_valid(fv_r), .sat_flag(sat_r)
    );

    fir_stream_param #(.DATA_W(16), .COEF_W(20), .TAPS(4), .OUT_W(16), .SHIFT(16), .ROUND(0)) dut_trn (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .clear(clear),
        .fir_d(fir_d_t), .fir_valid(fv_t), .sat_flag(sat_t)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: every valid output must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (fv_r || fv_t) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid actual=%0h/%0h required=none cycle=%0d", fir_d_r, fir_d_t, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("valid_rnd", 32'(fv_r), 32'd1);
                chk("valid_trn", 32'(fv_t), 32'd1);
                chk("fir_d_rnd", 32'(fir_d_r), 32'(mon_e.d_rnd));
                chk("fir_d_trn", 32'(fir_d_t), 32'(mon_e.d_trn));
                chk("sat_rnd", 32'(sat_r), 32'(mon_e.sat));
                chk("sat_trn", 32'(sat_t), 32'(mon_e.sat));
                chk("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            total++;
            $display("FAIL missing_valid actual=none required=%0h at cycle %0d", q[0].d_rnd, q[0].cyc);
            void'(q.pop_front());
        end
    end

    task automatic step(input logic dv, input logic [15:0] d, input logic we, input logic [1:0] a,
                        input logic [19:0] w, input logic clr, input logic ex,
                        input logic [15:0] er, input logic [15:0] et, input logic es);
        exp_t e;
        @(negedge clk);
        data_valid = dv; data = d; coef_we = we; coef_addr = a; coef_wdata = w; clear = clr;
        if (ex) begin
            e.d_rnd = er; e.d_trn = et; e.sat = es; e.cyc = cyc + 3;
            q.push_back(e);
        end
    endtask

    task automatic smp(input logic [15:0] d, input logic ex, input logic [15:0] er,
                       input logic [15:0] et, input logic es);
        step(1'b1, d, 1'b0, 2'd0, 20'h0, 1'b0, ex, er, et, es);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 2'd0, 20'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic wc(input logic [1:0] a, input logic [19:0] w);
        step(1'b0, 16'h0, 1'b1, a, w, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 16'h0, 1'b0, 2'd0, 20'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic impulse_seq();
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0100, 1'b1, 16'h0100, 16'h0100, 1'b0);
        smp(16'h0000, 1'b1, 16'h0080, 16'h0080, 1'b0);
        smp(16'h0000, 1'b1, 16'h0040, 16'h0040, 1'b0);
        smp(16'h0000, 1'b1, 16'h0020, 16'h0020, 1'b0);
        idle(4);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_fir_d_rnd", 32'(fir_d_r), 32'h0);
        chk("rst_fir_d_trn", 32'(fir_d_t), 32'h0);
        chk("rst_valid_rnd", 32'(fv_r), 32'h0);
        chk("rst_valid_trn", 32'(fv_t), 32'h0);
        chk("rst_sat_rnd", 32'(sat_r), 32'h0);
        chk("rst_sat_trn", 32'(sat_t), 32'h0);
        rst = 1'b0;

        // Impulse response
        wc(2'd0, 20'h10000); wc(2'd1, 20'h08000); wc(2'd2, 20'h04000); wc(2'd3, 20'h02000);
        impulse_seq();

        // Clear mid-stream together with a sample that must be dropped
        do_clear();
        smp(16'h0100, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0000, 1'b1, 16'h0020, 16'h0020, 1'b0);
        smp(16'h0100, 1'b1, 16'h0100, 16'h0100, 1'b0);
        idle(3);
        step(1'b1, 16'h0300, 1'b0, 2'd0, 20'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        impulse_seq();

        // Rounding vs truncation, then the coefficient write hazard
        do_clear();
        wc(2'd0, 20'h08000); wc(2'd1, 20'h00000); wc(2'd2, 20'h00000); wc(2'd3, 20'h00000);
        smp(16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0001, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0001, 1'b1, 16'h0001, 16'h0000, 1'b0);
        smp(16'hFFFF, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
        step(1'b1, 16'h0100, 1'b1, 2'd0, 20'h00000, 1'b0, 1'b1, 16'h0080, 16'h0080, 1'b0);
        smp(16'h0100, 1'b1, 16'h0000, 16'h0000, 1'b0);
        idle(4);

        // Positive saturation, sticky flag, clear of the flag
        do_clear();
        wc(2'd0, 20'h7FFFF); wc(2'd1, 20'h7FFFF); wc(2'd2, 20'h7FFFF); wc(2'd3, 20'h7FFFF);
        smp(16'h7FFF, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h7FFF, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h7FFF, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h7FFF, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
        idle(4);
        chk("sat_sticky_rnd", 32'(sat_r), 32'h1);
        chk("sat_sticky_trn", 32'(sat_t), 32'h1);
        do_clear();
        idle(1);
        chk("sat_cleared_rnd", 32'(sat_r), 32'h0);
        chk("sat_cleared_trn", 32'(sat_t), 32'h0);
        chk("fir_d_kept_rnd", 32'(fir_d_r), 32'h7FFF);

        // Negative saturation stream, then an asynchronous reset mid-stream
        smp(16'h8000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h8000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h8000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h8000, 1'b1, 16'h8000, 16'h8000, 1'b1);
        smp(16'h8000, 1'b1, 16'h8000, 16'h8000, 1'b1);
        smp(16'h8000, 1'b1, 16'h8000, 16'h8000, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("arst_fir_d_rnd", 32'(fir_d_r), 32'h0);
        chk("arst_fir_d_trn", 32'(fir_d_t), 32'h0);
        chk("arst_valid_rnd", 32'(fv_r), 32'h0);
        chk("arst_valid_trn", 32'(fv_t), 32'h0);
        chk("arst_sat_rnd", 32'(sat_r), 32'h0);
        chk("arst_sat_trn", 32'(sat_t), 32'h0);
        #1 rst = 1'b0;

        // Coefficients are zero after reset; first TAPS-1 samples give nothing
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0000, 1'b0, 16'h0, 16'h0, 1'b0);
        smp(16'h0100, 1'b1, 16'h0000, 16'h0000, 1'b0);
        smp(16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0);
        idle(5);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
